// File: rtl/lambda_moment_estimator_pkg.sv
// Shared Q8.8 constants and the moment estimator state encoding.
package lambda_moment_estimator_pkg;
  localparam int          Q_FRAC = 8;
  localparam logic [15:0] Q_MAX  = 16'h7FFF;
  localparam logic [15:0] Q_ONE  = 16'h0100;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_MEAN   = 2'd1,
    ST_SQUARE = 2'd2,
    ST_VAR    = 2'd3
  } state_e;
endpackage

// File: rtl/lambda_moment_estimator_q_square_sat.sv
// Combinational Q-format square: (x*x) >> FRAC_BITS, optionally saturated to Q_MAX.
// With SAT=0 the full-width square is returned for use in wide accumulators.
module q_square_sat
  import lambda_moment_estimator_pkg::*;
#(
  parameter int FRAC_BITS = Q_FRAC,
  parameter int OW        = 16,
  parameter bit SAT       = 1'b1
) (
  input  logic [15:0]   x_i,
  output logic [OW-1:0] sq_o
);
  logic signed [31:0] prod;
  logic        [31:0] shr;
  logic               ovf;

  always_comb begin
    prod = $signed(x_i) * $signed(x_i);
    // A square is never negative, so a logical shift is exact here.
    shr  = prod >> FRAC_BITS;
    ovf  = shr > 32'(Q_MAX);
    sq_o = (SAT && ovf) ? OW'(Q_MAX) : shr[OW-1:0];
  end
endmodule

// File: rtl/lambda_moment_estimator.sv
// Block mean/variance estimator over 2**LOG2_N Q8.8 samples of the lambda sampler stream.
// Accumulates one sample per accept, then spends three stall cycles finalizing the moments.
module lambda_moment_estimator
  import lambda_moment_estimator_pkg::*;
#(
  parameter int LOG2_N    = 3,
  parameter int FRAC_BITS = Q_FRAC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] sample_in,
  output logic        out_valid,
  output logic [15:0] mean_out,
  output logic [15:0] var_out
);
  localparam int SW = 16 + LOG2_N;
  localparam int QW = 24 + LOG2_N;

  state_e               state_q;
  logic                 ready_q;
  logic [LOG2_N-1:0]    count_q;
  logic signed [SW-1:0] sum_q, sum_d;
  logic [QW-1:0]        sumsq_q, sumsq_d;
  logic [15:0]          mean_q, mean_d;
  logic [15:0]          msq_q, msq_d;
  logic [15:0]          sq_q;
  logic                 out_valid_q;
  logic [15:0]          mean_out_q, var_out_q, var_d;

  logic                 accept;
  logic [23:0]          sample_sq;
  logic [15:0]          mean_sq;
  logic [QW-1:0]        msq_shr;
  logic signed [16:0]   diff;

  q_square_sat #(.FRAC_BITS(FRAC_BITS), .OW(24), .SAT(1'b0)) u_acc_sq (
    .x_i  (sample_in),
    .sq_o (sample_sq)
  );

  q_square_sat #(.FRAC_BITS(FRAC_BITS), .OW(16), .SAT(1'b1)) u_mean_sq (
    .x_i  (mean_q),
    .sq_o (mean_sq)
  );

  assign accept = in_valid && ready_q;

  always_comb begin
    sum_d   = sum_q + {{LOG2_N{sample_in[15]}}, sample_in};
    sumsq_d = sumsq_q + {{LOG2_N{1'b0}}, sample_sq};
    // The upper 16 bits of sum are exactly sum >>> LOG2_N, i.e. floor division by N.
    mean_d  = sum_q[LOG2_N +: 16];
    msq_shr = sumsq_q >> LOG2_N;
    msq_d   = (msq_shr > QW'(Q_MAX)) ? Q_MAX : msq_shr[15:0];
    diff    = $signed({1'b0, msq_q}) - $signed({1'b0, sq_q});
    var_d   = diff[16] ? 16'h0000 : diff[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_ACCUM;
      ready_q     <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      sumsq_q     <= '0;
      mean_q      <= '0;
      msq_q       <= '0;
      sq_q        <= '0;
      out_valid_q <= 1'b0;
      mean_out_q  <= '0;
      var_out_q   <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_ACCUM: begin
          ready_q <= 1'b1;
          if (accept) begin
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
            count_q <= count_q + LOG2_N'(1);
            if (&count_q) begin
              state_q <= ST_MEAN;
              ready_q <= 1'b0;
            end
          end
        end
        ST_MEAN: begin
          mean_q  <= mean_d;
          msq_q   <= msq_d;
          state_q <= ST_SQUARE;
        end
        ST_SQUARE: begin
          sq_q    <= mean_sq;
          state_q <= ST_VAR;
        end
        ST_VAR: begin
          mean_out_q  <= mean_q;
          var_out_q   <= var_d;
          out_valid_q <= 1'b1;
          count_q     <= '0;
          sum_q       <= '0;
          sumsq_q     <= '0;
          ready_q     <= 1'b1;
          state_q     <= ST_ACCUM;
        end
        default: begin
          state_q <= ST_ACCUM;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign mean_out  = mean_out_q;
  assign var_out   = var_out_q;
endmodule

// File: tb/tb_lambda_moment_estimator.sv
// Self-checking bench: directed blocks plus random blocks against an integer-arithmetic model.
module tb_lambda_moment_estimator;
  localparam int N = 8;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sample_in;
  logic        out_valid;
  logic [15:0] mean_out;
  logic [15:0] var_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          due;
    logic [15:0] m;
    logic [15:0] v;
  } exp_t;

  exp_t        pend[$];
  int          part[$];
  int          cyc     = 0;
  int          low_run = 0;
  bit          post_rst = 1'b1;
  logic [15:0] hold_m  = 16'h0000;
  logic [15:0] hold_v  = 16'h0000;

  lambda_moment_estimator dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sample_in (sample_in),
    .out_valid (out_valid),
    .mean_out  (mean_out),
    .var_out   (var_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  // Reference: plain integer mean/variance with the Q8.8 truncation and 0x7FFF result clipping.
  function automatic void model(input int xs[$], output logic [15:0] m, output logic [15:0] v);
    int s, sq, mean, msq, m2, d;
    s = 0;
    sq = 0;
    foreach (xs[i]) begin
      s  += xs[i];
      sq += (xs[i] * xs[i]) / 256;
    end
    mean = floor_div(s, N);
    msq  = sq / N;
    if (msq > 32767) msq = 32767;
    m2 = (mean * mean) / 256;
    if (m2 > 32767) m2 = 32767;
    d = msq - m2;
    if (d < 0) d = 0;
    m = mean[15:0];
    v = d[15:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [15:0] em, ev;
    cyc++;
    if (!reset) begin
      part.delete();
      pend.delete();
      hold_m   = 16'h0000;
      hold_v   = 16'h0000;
      low_run  = 0;
      post_rst = 1'b1;
    end else begin
      if (out_valid) begin
        if (pend.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          e = pend.pop_front();
          chk("latency", cyc, e.due);
          chk("mean_out", {16'h0, mean_out}, {16'h0, e.m});
          chk("var_out", {16'h0, var_out}, {16'h0, e.v});
          hold_m = e.m;
          hold_v = e.v;
        end
      end else begin
        if (pend.size() > 0 && cyc >= pend[0].due) begin
          chk("missing_out_valid", 32'd0, 32'd1);
          void'(pend.pop_front());
        end
        chk("hold_mean", {16'h0, mean_out}, {16'h0, hold_m});
        chk("hold_var", {16'h0, var_out}, {16'h0, hold_v});
      end
      if (!in_ready) begin
        low_run++;
      end else begin
        if (low_run > 0 && !post_rst) chk("stall_len", low_run, 3);
        low_run  = 0;
        post_rst = 1'b0;
      end
      if (in_valid && in_ready) begin
        part.push_back(int'($signed(sample_in)));
        if (part.size() == N) begin
          model(part, em, ev);
          e.due = cyc + 4;
          e.m   = em;
          e.v   = ev;
          pend.push_back(e);
          part.delete();
        end
      end
    end
  end

  task automatic send(input logic [15:0] s, input int max_gap);
    bit acc;
    int gap;
    acc       = 1'b0;
    sample_in = s;
    in_valid  = 1'b1;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_timeout", {31'h0, acc}, 32'd1);
    if (max_gap > 0) begin
      gap = $urandom_range(max_gap, 0);
      if (gap > 0) begin
        in_valid  = 1'b0;
        sample_in = 16'($urandom);
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_block(input logic [15:0] blk[N], input int max_gap, input bit keep);
    for (int i = 0; i < N; i++) send(blk[i], max_gap);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200 && pend.size() > 0; t++) @(posedge clk);
    #1;
    chk("drain", pend.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill(output logic [15:0] blk[N], input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < N; i++) blk[i] = (i % 2 == 0) ? a : b;
  endtask

  initial begin
    logic [15:0] blk[N];
    int mode;
    reset     = 1'b0;
    in_valid  = 1'b0;
    sample_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_mean", {16'h0, mean_out}, 32'd0);
    chk("rst_var", {16'h0, var_out}, 32'd0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
    reset = 1'b1;
    chk("release_in_ready_low", {31'h0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("release_in_ready_high", {31'h0, in_ready}, 32'd1);

    fill(blk, 16'h0100, 16'h0100);
    send_block(blk, 2, 1'b0);
    wait_idle();
    fill(blk, 16'h0100, 16'hFF00);
    send_block(blk, 2, 1'b0);
    wait_idle();
    fill(blk, 16'h0200, 16'h0000);
    send_block(blk, 0, 1'b1);
    fill(blk, 16'hFE00, 16'hFE00);
    send_block(blk, 0, 1'b0);
    wait_idle();
    fill(blk, 16'h0001, 16'h0000);
    blk[2] = 16'h0000; blk[4] = 16'h0000; blk[6] = 16'h0000;
    send_block(blk, 1, 1'b0);
    wait_idle();
    blk[0] = 16'hFFFF;
    send_block(blk, 1, 1'b0);
    wait_idle();
    fill(blk, 16'h7FFF, 16'h7FFF);
    send_block(blk, 1, 1'b0);
    wait_idle();

    // Reset after 5 accepted samples: partial block must vanish.
    for (int i = 0; i < 5; i++) send(16'h0500, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("midblk_rst_mean", {16'h0, mean_out}, 32'd0);
    chk("midblk_rst_var", {16'h0, var_out}, 32'd0);
    chk("midblk_rst_in_ready", {31'h0, in_ready}, 32'd0);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midblk_no_out_valid", {31'h0, out_valid}, 32'd0);
    fill(blk, 16'h0300, 16'h0300);
    send_block(blk, 1, 1'b0);
    wait_idle();

    // Reset while finalizing: the result must never appear.
    fill(blk, 16'h0400, 16'h0400);
    send_block(blk, 0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("finrst_mean", {16'h0, mean_out}, 32'd0);
    chk("finrst_var", {16'h0, var_out}, 32'd0);

    for (int b = 0; b < 20; b++) begin
      mode = $urandom_range(2, 0);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0:       blk[i] = 16'($urandom);
          1:       blk[i] = 16'($urandom_range(2047, 0) - 1024);
          default: blk[i] = 16'(int'($urandom_range(511, 0)) - 256 + 16'sh0A00);
        endcase
      end
      send_block(blk, $urandom_range(2, 0), 1'($urandom_range(1, 0)));
    end
    in_valid = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lambda_moment_estimator.md
Name: lambda_moment_estimator

Overview:
- Inverse of the lambda sampling layer: consumes a stream of sampled latent values z = mean + sqrt(softplus(var))*eps.
- Over blocks of N samples, recovers the empirical mean and variance of the stream.
- Used on-chip to close the loop on the reparameterization path: checks the sampler/PRNG statistics and feeds KL/monitoring logic.
- All data is signed 16-bit fixed point, Q8.8, matching the fixed_point_multiply/fixed_point_add datapath.

Parameters:
- LOG2_N, 3, log2 of samples per estimation block (N = 8); legal range 1..8.
- FRAC_BITS, 8, fractional bits of the Q format.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- in_valid  input  1  sample_in valid
- in_ready  output  1  block accepts a sample this cycle
- sample_in  input  16  signed Q8.8 sample (lambda_out stream)
- out_valid  output  1  one-cycle pulse: mean_out/var_out updated
- mean_out  output  16  signed Q8.8 block mean
- var_out  output  16  Q8.8 block variance, always in 0..0x7FFF

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=ACCUM; count, sum and sumsq cleared.
  - out_valid=0, mean_out=0, var_out=0.
  - in_ready goes high the cycle after reset is released.
  - A reset mid-block or mid-finalize discards all partial data; no out_valid is produced.
- Handshake: a sample is accepted on an edge where in_valid && in_ready. in_ready = (state==ACCUM). When in_ready is low, in_valid is ignored and never queued.
- ACCUM, on each accept:
  - sum += sign-extended sample; sum width 16+LOG2_N.
  - sumsq += (sample*sample) >> FRAC_BITS; product is 32-bit signed and the result is non-negative; sumsq width 24+LOG2_N, unsigned.
  - count += 1.
  - On the N-th accept, go to MEAN.
- MEAN, one cycle:
  - mean_r = sum >>> LOG2_N (arithmetic shift, rounds toward -inf); always fits in 16 bits.
  - msq_r = sumsq >> LOG2_N, saturated to 0x7FFF.
  - Go to SQUARE.
- SQUARE, one cycle: sq_r = (mean_r*mean_r) >> FRAC_BITS, saturated to 0x7FFF. Go to VAR.
- VAR, one cycle: diff = msq_r - sq_r as a signed 17-bit value; clamp negatives to 0.
- Exit from VAR (registered on the same edge):
  - mean_out <= mean_r; var_out <= clamped diff; out_valid=1 for exactly one cycle.
  - Accumulators and count cleared; state=ACCUM.
- Latency: out_valid is high in the cycle after the 3rd edge following the edge that accepts the N-th sample. in_ready is low for exactly 3 cycles per block.
- mean_out/var_out hold their value between out_valid pulses.
- Back-to-back: a sample presented while out_valid is high is accepted as sample 1 of the next block.
- No overflow is possible in sum or sumsq at the chosen widths; saturation applies only at the 16-bit result stage.

Decomposition:
- Shared package (alongside the existing fixed-point constants): Q_FRAC=8, Q_MAX=16'h7FFF, Q_ONE=16'h0100, state encoding (ACCUM, MEAN, SQUARE, VAR).
- One natural sub-module: q_square_sat. Combinational: 16-bit signed in, (x*x)>>FRAC_BITS saturated to 0x7FFF. Instanced in both the accumulate path and the SQUARE stage.

Test Plan:
- N=8 samples, all 0x0100 (1.0) -> out_valid once, mean_out=0x0100, var_out=0x0000; in_ready low exactly 3 cycles after the 8th accept.
- Alternating 0x0100/0xFF00 (+1/-1) -> mean_out=0x0000, var_out=0x0100.
- Alternating 0x0200/0x0000 -> mean_out=0x0100, var_out=0x0100. Then a second block of all 0xFE00 (-2.0) presented back-to-back, with in_valid held high through the stall -> mean_out=0xFE00, var_out=0; exactly 8 samples accepted per block.
- All 0x7FFF -> msq and mean^2 both saturate; mean_out=0x7FFF, var_out=0x0000, no wrap.
- Rounding: samples 0x0001 followed by seven 0x0000 -> mean_out=0x0000 (floor); same with 0xFFFF -> mean_out=0xFFFF.
- Reset low after 5 accepted samples, then released -> outputs stay 0 with no out_valid; a fresh block of 8 x 0x0300 then yields mean_out=0x0300, var_out=0.
